// File: rtl/ram_rd_stream.sv
// Valid/ready read front-end for ram_sync: issues one RAM read per accepted request,
// captures rdata at its fixed arrival cycle and returns responses in order.
module ram_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int OUTPUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_rvalid,
    output logic                  ram_oreg_cen,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int L   = 1 + OUTPUT_REG;
    localparam int CAP = L + 1;
    localparam int CW  = $clog2(CAP + 1);
    localparam int PW  = (CAP > 1) ? $clog2(CAP) : 1;

    logic [L-1:0]          v;
    logic [DATA_WIDTH-1:0] entry [CAP];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outst;
    logic                  acc;
    logic                  pop;
    logic                  wr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(CAP - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outputs are gated by rst so nothing escapes before the reset edge clears state.
    assign rsp_valid    = rst && (count != '0);
    assign pop          = rsp_valid && rsp_ready;
    assign req_ready    = rst && ((outst < CW'(CAP)) || pop);
    assign acc          = req_valid && req_ready;
    assign ram_rvalid   = acc;
    assign ram_raddr    = req_addr;
    assign wr           = v[L-1];
    assign ram_oreg_cen = (OUTPUT_REG != 0) ? (rst && v[0]) : 1'b0;
    assign rsp_data     = entry[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            v <= '0;
        end else begin
            v[0] <= acc;
            for (int unsigned i = 1; i < L; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            outst  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (wr && !pop) begin
                count <= count + 1'b1;
            end else if (!wr && pop) begin
                count <= count - 1'b1;
            end
            if (acc && !pop) begin
                outst <= outst + 1'b1;
            end else if (!acc && pop) begin
                outst <= outst - 1'b1;
            end
        end
    end

    // count <= outst <= CAP, so the tail slot is always free when a word lands.
    always_ff @(posedge clk) begin
        if (wr) begin
            entry[wr_ptr] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Directed bench for ram_rd_stream: runs the same directed sequence against an
// OUTPUT_REG=0 and an OUTPUT_REG=1 instance, each backed by a small ram_sync model.
module tb_ram_rd_stream;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][7:0]  req_addr;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] rsp_data;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][7:0]  ram_raddr;
    logic [1:0]       ram_rvalid;
    logic [1:0]       ram_oreg_cen;
    logic [1:0][31:0] ram_rdata;
    logic [1:0][31:0] rd_q;
    logic [1:0][31:0] o_q;
    int               rv_cnt [2];

    int               tests = 0;
    int               fails = 0;
    int               pops;
    int               accs;
    logic [31:0]      sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_rd_stream #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OUTPUT_REG(g)) u_dut (
            .clk(clk), .rst(rst),
            .req_addr(req_addr[g]), .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .rsp_data(rsp_data[g]), .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .ram_raddr(ram_raddr[g]), .ram_rvalid(ram_rvalid[g]),
            .ram_oreg_cen(ram_oreg_cen[g]), .ram_rdata(ram_rdata[g])
        );
    end

    // ram_sync model, preloaded with mem[a] = 32'hA5000000 | a
    initial begin
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_rvalid[i]) begin
                rd_q[i]   <= 32'hA500_0000 | {24'h0, ram_raddr[i]};
                rv_cnt[i] <= rv_cnt[i] + 1;
            end
            if (ram_oreg_cen[i]) o_q[i] <= rd_q[i];
        end
    end
    assign ram_rdata[0] = rd_q[0];
    assign ram_rdata[1] = o_q[1];

    function automatic logic [31:0] mval(input logic [7:0] a);
        return 32'hA500_0000 | {24'h0, a};
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    // Scores the current cycle (pop vs scoreboard, record acceptance) then advances.
    task automatic cyc(input int d);
        #1;
        if (rsp_valid[d] && rsp_ready[d]) begin
            chk("rsp_expected", d, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("rsp_data", d, rsp_data[d], sb.pop_front());
            pops++;
        end
        if (req_valid[d] && req_ready[d]) begin
            sb.push_back(mval(req_addr[d]));
            accs++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst = 1'b0;
        req_valid = '0;
        req_valid[d] = 1'b1;
        rsp_ready = '1;
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rst_req_ready", d, 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            chk("rst_ram_rvalid", d, 32'(ram_rvalid[d]), 32'd0);
            chk("rst_oreg_cen", d, 32'(ram_oreg_cen[d]), 32'd0);
        end
        req_valid = '0;
        rsp_ready = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        pops = 0;
        accs = 0;
    endtask

    task automatic single(input int d, input logic [7:0] a);
        int lat;
        int r0;
        lat = d + 2;
        req_addr[d]  = a;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        #1;
        chk("single_ready", d, 32'(req_ready[d]), 32'd1);
        chk("single_raddr", d, 32'(ram_raddr[d]), 32'(a));
        r0 = rv_cnt[d];
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            #1;
            chk("lat_valid", d, 32'(rsp_valid[d]), 32'(k == lat));
            chk("oreg_cen", d, 32'(ram_oreg_cen[d]), 32'(d == 1 && k == 1));
            if (k == lat) chk("single_data", d, rsp_data[d], mval(a));
            @(posedge clk);
            #1;
        end
        #1;
        chk("single_popped", d, 32'(rsp_valid[d]), 32'd0);
        chk("rvalid_pulses", d, 32'(rv_cnt[d] - r0), 32'd1);
    endtask

    task automatic stream(input int d);
        pops = 0;
        accs = 0;
        rsp_ready[d] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = 8'(i);
            #1;
            chk("stream_ready", d, 32'(req_ready[d]), 32'd1);
            cyc(d);
        end
        req_valid[d] = 1'b0;
        for (int i = 0; i < 8 && sb.size() != 0; i++) cyc(d);
        chk("stream_drained", d, 32'(sb.size()), 32'd0);
        chk("stream_pops", d, 32'(pops), 32'd64);
    endtask

    task automatic backpressure(input int d);
        pops = 0;
        accs = 0;
        rsp_ready[d] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = 8'(32'h20 + accs);
            cyc(d);
        end
        #1;
        chk("bp_accepted", d, 32'(accs), 32'(d + 2));
        chk("bp_ready", d, 32'(req_ready[d]), 32'd0);
        chk("bp_valid", d, 32'(rsp_valid[d]), 32'd1);
        chk("bp_data", d, rsp_data[d], mval(8'h20));
        cyc(d);
        chk("bp_data_stable", d, rsp_data[d], mval(8'h20));
        chk("bp_ready_held", d, 32'(req_ready[d]), 32'd0);
        rsp_ready[d] = 1'b1;
        for (int j = 0; j < 20 && !(accs == 5 && sb.size() == 0); j++) begin
            req_valid[d] = (accs < 5);
            req_addr[d]  = 8'(32'h20 + accs);
            cyc(d);
        end
        req_valid[d] = 1'b0;
        chk("bp_pops", d, 32'(pops), 32'd5);
    endtask

    task automatic random_wrap(input int d);
        logic [7:0] seq [3];
        seq[0] = 8'hFE;
        seq[1] = 8'hFF;
        seq[2] = 8'h00;
        pops = 0;
        accs = 0;
        for (int c = 0; c < 1000; c++) begin
            req_valid[d] = ($urandom_range(0, 3) != 0);
            req_addr[d]  = seq[accs % 3];
            rsp_ready[d] = $urandom_range(0, 1) != 0;
            cyc(d);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc(d);
        chk("rand_drained", d, 32'(sb.size()), 32'd0);
        chk("rand_balance", d, 32'(pops), 32'(accs));
    endtask

    task automatic mid_reset(input int d);
        rsp_ready[d] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = 8'(32'h30 + j);
            cyc(d);
        end
        req_valid[d] = 1'b0;
        chk("mr_outstanding", d, 32'(accs), 32'd2);
        rst = 1'b0;
        #1;
        chk("mr_req_ready", d, 32'(req_ready[d]), 32'd0);
        chk("mr_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        rsp_ready[d] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("mr_no_rsp", d, 32'(rsp_valid[d]), 32'd0);
            @(posedge clk);
            #1;
        end
        single(d, 8'h07);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_addr  = '0;
        req_valid = '0;
        rsp_ready = '0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            single(d, 8'h12);
            stream(d);
            backpressure(d);
            random_wrap(d);
            do_reset(d);
            mid_reset(d);
            req_valid = '0;
            rsp_ready = '0;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
